// File: rtl/meas_pkg.sv
// ============================================================================
// Module : meas_pkg
// Brief  : Shared types and constants for the meas_ctrl measurement block.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package meas_pkg;

  localparam int CNT_W              = 32;
  localparam int TIMEOUT_CYCLES_DEF = 50_000_000;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_ACCUM     = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

endpackage : meas_pkg

`default_nettype wire

// File: rtl/meas_accum.sv
// ============================================================================
// Module : meas_accum
// Brief  : Sample accumulator for meas_ctrl; tracks min/max when
//          MEAS_CTRL_MINMAX_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module meas_accum
  import meas_pkg::*;
#(
  parameter int N_LOG2 = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_add,
  input  logic [CNT_W-1:0] i_sample,
`ifdef MEAS_CTRL_MINMAX_EN
  output logic [CNT_W-1:0] o_min_next,
  output logic [CNT_W-1:0] o_max_next,
`endif
  output logic [CNT_W-1:0] o_avg_next
);

  localparam int SUM_W = CNT_W + N_LOG2;

  logic [SUM_W-1:0] r_sum;
  logic [SUM_W-1:0] w_sum_next;

  // Average of the sum including the sample being added this cycle, so the
  // caller can register the final result on the same edge as the last add.
  always_comb begin
    w_sum_next = r_sum;
    if (i_add) begin
      w_sum_next = r_sum + {{N_LOG2{1'b0}}, i_sample};
    end
  end

  assign o_avg_next = w_sum_next[SUM_W-1:N_LOG2];

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_sum <= '0;
    end else begin
      r_sum <= w_sum_next;
    end
  end

`ifdef MEAS_CTRL_MINMAX_EN
  logic [CNT_W-1:0] r_min;
  logic [CNT_W-1:0] r_max;

  assign o_min_next = (i_add && (i_sample < r_min)) ? i_sample : r_min;
  assign o_max_next = (i_add && (i_sample > r_max)) ? i_sample : r_max;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_min <= '1;
      r_max <= '0;
    end else begin
      r_min <= o_min_next;
      r_max <= o_max_next;
    end
  end
`endif

endmodule : meas_accum

`default_nettype wire

// File: rtl/meas_ctrl.sv
// ============================================================================
// Module : meas_ctrl
// Brief  : Averages 2**N_LOG2 pulse-counter samples per triggered run with a
//          per-sample watchdog. Define MEAS_CTRL_MINMAX_EN for min/max outputs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module meas_ctrl
  import meas_pkg::*;
#(
  parameter int N_LOG2         = 3,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trigger,
  output logic             cnt_start,
  input  logic             cnt_busy,
  input  logic [CNT_W-1:0] cnt_val,
  output logic             busy,
  output logic [CNT_W-1:0] result,
  output logic             result_valid,
`ifdef MEAS_CTRL_MINMAX_EN
  output logic [CNT_W-1:0] result_min,
  output logic [CNT_W-1:0] result_max,
`endif
  output logic             timeout
);

  localparam int              WD_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [N_LOG2-1:0] IDX_LAST = '1;

  state_t              r_state;
  state_t              w_next;
  logic [N_LOG2-1:0]   r_idx;
  logic [WD_W-1:0]     r_wd;
  logic [CNT_W-1:0]    r_sample;
  logic [CNT_W-1:0]    r_result;
  logic                r_timeout;

  logic                w_start;
  logic                w_clear;
  logic                w_capture;
  logic                w_expire;
  logic                w_add;
  logic                w_load;
  logic                w_wd_hit;
  logic [CNT_W-1:0]    w_avg_next;

  assign w_wd_hit = (r_wd >= WD_LAST);

  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_clear   = 1'b0;
    w_capture = 1'b0;
    w_expire  = 1'b0;
    w_add     = 1'b0;
    w_load    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (trigger) begin
          w_clear = 1'b1;
          w_next  = ST_ISSUE;
        end
      end
      // A counter still busy from an aborted run must finish before restart.
      ST_ISSUE: begin
        if (!cnt_busy) begin
          w_start = 1'b1;
          w_next  = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (w_wd_hit) begin
          w_expire = 1'b1;
          w_next   = ST_IDLE;
        end else if (cnt_busy) begin
          w_next = ST_WAIT_DONE;
        end
      end
      // Capture beats a watchdog expiring in the same cycle.
      ST_WAIT_DONE: begin
        if (!cnt_busy) begin
          w_capture = 1'b1;
          w_next    = ST_ACCUM;
        end else if (w_wd_hit) begin
          w_expire = 1'b1;
          w_next   = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        w_add = 1'b1;
        if (r_idx == IDX_LAST) begin
          w_load = 1'b1;
          w_next = ST_DONE;
        end else begin
          w_next = ST_ISSUE;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Result registers load on the ACCUM->DONE edge so they are already
  // valid during the DONE cycle that raises result_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx     <= '0;
      r_wd      <= '0;
      r_sample  <= '0;
      r_result  <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_clear) begin
        r_idx     <= '0;
        r_timeout <= 1'b0;
      end else if (w_add && !w_load) begin
        r_idx <= r_idx + N_LOG2'(1);
      end

      if (w_expire) begin
        r_timeout <= 1'b1;
      end

      if (w_clear || (r_state == ST_ISSUE)) begin
        r_wd <= '0;
      end else if ((r_state == ST_WAIT_BUSY) || (r_state == ST_WAIT_DONE)) begin
        r_wd <= r_wd + WD_W'(1);
      end

      if (w_capture) begin
        r_sample <= cnt_val;
      end

      if (w_load) begin
        r_result <= w_avg_next;
      end
    end
  end

`ifdef MEAS_CTRL_MINMAX_EN
  logic [CNT_W-1:0] w_min_next;
  logic [CNT_W-1:0] w_max_next;
  logic [CNT_W-1:0] r_min;
  logic [CNT_W-1:0] r_max;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_min <= '0;
      r_max <= '0;
    end else if (w_load) begin
      r_min <= w_min_next;
      r_max <= w_max_next;
    end
  end

  assign result_min = r_min;
  assign result_max = r_max;
`endif

  meas_accum #(
    .N_LOG2 (N_LOG2)
  ) u_accum (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_clear),
    .i_add      (w_add),
    .i_sample   (r_sample),
`ifdef MEAS_CTRL_MINMAX_EN
    .o_min_next (w_min_next),
    .o_max_next (w_max_next),
`endif
    .o_avg_next (w_avg_next)
  );

  assign cnt_start    = w_start;
  assign busy         = (r_state != ST_IDLE);
  assign result       = r_result;
  assign result_valid = (r_state == ST_DONE);
  assign timeout      = r_timeout;

endmodule : meas_ctrl

`default_nettype wire

// File: tb/tb_meas_ctrl.sv
// ============================================================================
// Module : tb_meas_ctrl
// Brief  : Self-checking bench for meas_ctrl (unit 0: N_LOG2=2, unit 1:
//          N_LOG2=1, both TIMEOUT_CYCLES=100) with a pulse-counter model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_meas_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  trig;
  logic [1:0]  start;
  logic [1:0]  cbusy;
  logic [1:0]  obusy;
  logic [1:0]  rv;
  logic [1:0]  tout;
  logic [31:0] cval [2];
  logic [31:0] res0, res1;
`ifdef MEAS_CTRL_MINMAX_EN
  logic [31:0] mn0, mx0, mn1, mx1;
`endif

  always #5 clk = ~clk;

  meas_ctrl #(.N_LOG2(2), .TIMEOUT_CYCLES(100)) u_dut0 (
    .clk(clk), .rst(rst), .trigger(trig[0]), .cnt_start(start[0]),
    .cnt_busy(cbusy[0]), .cnt_val(cval[0]), .busy(obusy[0]), .result(res0),
    .result_valid(rv[0]),
`ifdef MEAS_CTRL_MINMAX_EN
    .result_min(mn0), .result_max(mx0),
`endif
    .timeout(tout[0])
  );

  meas_ctrl #(.N_LOG2(1), .TIMEOUT_CYCLES(100)) u_dut1 (
    .clk(clk), .rst(rst), .trigger(trig[1]), .cnt_start(start[1]),
    .cnt_busy(cbusy[1]), .cnt_val(cval[1]), .busy(obusy[1]), .result(res1),
    .result_valid(rv[1]),
`ifdef MEAS_CTRL_MINMAX_EN
    .result_min(mn1), .result_max(mx1),
`endif
    .timeout(tout[1])
  );

  typedef struct {
    int          u;
    logic [31:0] res;
    logic [31:0] mn;
    logic [31:0] mx;
  } exp_t;

  typedef struct {
    logic [3:0][31:0] s;
    logic [31:0]      exp;
  } vec_t;

  exp_t        sb[$];
  int          rd = 0;
  vec_t        tbl[6];
  logic [31:0] samp [2][8];
  int          lat[2], cnt[2], idx[2], nstart[2], nvalid[2], dropcyc[2], startcyc[2];
  bit          hold[2], pend[2];
  int          cyc = 0, viol = 0;
  int          n_cmp = 0, n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // One clock: monitor outputs, advance counter model, then sample cnt_start.
  task automatic tick();
    logic [31:0] r;
    @(negedge clk);
    cyc++;
    for (int u = 0; u < 2; u++) begin
      r = (u == 0) ? res0 : res1;
      if (rv[u]) begin
        nvalid[u]++;
        check("valid_latency", 64'(cyc - dropcyc[u]), 64'd2);
        if (rd < sb.size()) begin
          check("sb_unit", 64'(u), 64'(sb[rd].u));
          check("sb_result", {32'd0, r}, {32'd0, sb[rd].res});
`ifdef MEAS_CTRL_MINMAX_EN
          check("sb_min", {32'd0, (u == 0) ? mn0 : mn1}, {32'd0, sb[rd].mn});
          check("sb_max", {32'd0, (u == 0) ? mx0 : mx1}, {32'd0, sb[rd].mx});
`endif
          rd++;
        end else begin
          check("sb_unexpected_valid", 64'd1, 64'd0);
        end
      end
    end
    for (int u = 0; u < 2; u++) begin
      if (pend[u]) begin
        cbusy[u] = 1'b1;
        cnt[u]   = lat[u];
        pend[u]  = 1'b0;
      end else if (cbusy[u] && !hold[u]) begin
        if (cnt[u] == 0) begin
          cbusy[u]   = 1'b0;
          cval[u]    = samp[u][idx[u] % 8];
          idx[u]++;
          dropcyc[u] = cyc;
        end else begin
          cnt[u]--;
        end
      end
    end
    #1;
    for (int u = 0; u < 2; u++) begin
      if (start[u]) begin
        nstart[u]++;
        startcyc[u] = cyc;
        if (cbusy[u]) viol++;
        pend[u] = 1'b1;
      end
    end
  endtask

  task automatic prep(input int u);
    cbusy[u] = 1'b0;
    pend[u]  = 1'b0;
    cnt[u]   = 0;
    idx[u]   = 0;
  endtask

  task automatic launch(input int u);
    trig[u] = 1'b1;
    tick();
    trig[u] = 1'b0;
  endtask

  task automatic wait_idle(input int u, input int lim, input string nm);
    int k = 0;
    while (obusy[u] && k < lim) begin
      tick();
      k++;
    end
    check(nm, {63'd0, obusy[u]}, 64'd0);
  endtask

  task automatic push_exp(input int u, input int n, input logic [31:0] avg);
    exp_t e;
    e.u   = u;
    e.res = avg;
    e.mn  = samp[u][0];
    e.mx  = samp[u][0];
    for (int i = 1; i < n; i++) begin
      if (samp[u][i] < e.mn) e.mn = samp[u][i];
      if (samp[u][i] > e.mx) e.mx = samp[u][i];
    end
    sb.push_back(e);
  endtask

  function automatic vec_t mk(input logic [31:0] a, b, c, d, e);
    vec_t v;
    v.s[0] = a; v.s[1] = b; v.s[2] = c; v.s[3] = d;
    v.exp  = e;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got stuck, want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int s0, v0, k;
    rst   = 1'b1;
    trig  = 2'b00;
    cbusy = 2'b00;
    cval[0] = '0; cval[1] = '0;
    for (int u = 0; u < 2; u++) begin
      lat[u] = 2; hold[u] = 1'b0; pend[u] = 1'b0; cnt[u] = 0; idx[u] = 0;
      nstart[u] = 0; nvalid[u] = 0; dropcyc[u] = 0; startcyc[u] = 0;
      for (int i = 0; i < 8; i++) samp[u][i] = '0;
    end
    tbl[0] = mk(32'd10, 32'd20, 32'd30, 32'd41, 32'd25);
    tbl[1] = mk(32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    tbl[2] = mk(32'd3, 32'd3, 32'd3, 32'd4, 32'd3);
    tbl[3] = mk(32'd100, 32'd200, 32'd300, 32'd400, 32'd250);
    tbl[4] = mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tbl[5] = mk(32'd1, 32'd2, 32'd3, 32'd1, 32'd1);

    repeat (3) tick();
    for (int u = 0; u < 2; u++) begin
      check("rst_busy", {63'd0, obusy[u]}, 64'd0);
      check("rst_valid", {63'd0, rv[u]}, 64'd0);
      check("rst_timeout", {63'd0, tout[u]}, 64'd0);
      check("rst_start", {63'd0, start[u]}, 64'd0);
    end
    check("rst_result0", {32'd0, res0}, 64'd0);
    check("rst_result1", {32'd0, res1}, 64'd0);
    rst = 1'b0;
    tick();

    // Table-driven runs on unit 0 (4 samples each).
    for (int i = 0; i < 6; i++) begin
      prep(0);
      for (int j = 0; j < 4; j++) samp[0][j] = tbl[i].s[j];
      lat[0] = 1 + (i % 3);
      push_exp(0, 4, tbl[i].exp);
      s0 = nstart[0];
      v0 = nvalid[0];
      launch(0);
      wait_idle(0, 200, "vec_done");
      check("vec_starts", 64'(nstart[0] - s0), 64'd4);
      check("vec_valids", 64'(nvalid[0] - v0), 64'd1);
      check("vec_timeout", {63'd0, tout[0]}, 64'd0);
      repeat (3) tick();
      check("vec_result_hold", {32'd0, res0}, {32'd0, tbl[i].exp});
    end

    // Trigger during WAIT_DONE is ignored.
    prep(0);
    samp[0][0] = 32'd7; samp[0][1] = 32'd8; samp[0][2] = 32'd9; samp[0][3] = 32'd10;
    lat[0] = 6;
    push_exp(0, 4, 32'd8);
    s0 = nstart[0];
    v0 = nvalid[0];
    launch(0);
    k = 0;
    while (!cbusy[0] && k < 20) begin tick(); k++; end
    tick();
    trig[0] = 1'b1;
    tick();
    trig[0] = 1'b0;
    wait_idle(0, 200, "ign_done");
    repeat (10) tick();
    check("ign_no_rerun", {63'd0, obusy[0]}, 64'd0);
    check("ign_starts", 64'(nstart[0] - s0), 64'd4);
    check("ign_valids", 64'(nvalid[0] - v0), 64'd1);
    check("ign_result", {32'd0, res0}, 64'd8);

    // Reset during WAIT_DONE of sample 2, then a full clean run.
    prep(0);
    for (int j = 0; j < 4; j++) samp[0][j] = 32'd1000;
    lat[0] = 8;
    s0 = nstart[0];
    launch(0);
    k = 0;
    while (!((nstart[0] == s0 + 2) && cbusy[0]) && k < 100) begin tick(); k++; end
    check("rst_mid_reached", 64'(nstart[0] - s0), 64'd2);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_busy", {63'd0, obusy[0]}, 64'd0);
    check("mid_rst_valid", {63'd0, rv[0]}, 64'd0);
    check("mid_rst_result", {32'd0, res0}, 64'd0);
    check("mid_rst_timeout", {63'd0, tout[0]}, 64'd0);
    check("mid_rst_start", {63'd0, start[0]}, 64'd0);
    prep(0);
    samp[0][0] = 32'd4; samp[0][1] = 32'd8; samp[0][2] = 32'd12; samp[0][3] = 32'd16;
    lat[0] = 2;
    push_exp(0, 4, 32'd10);
    s0 = nstart[0];
    launch(0);
    wait_idle(0, 200, "post_rst_done");
    check("post_rst_starts", 64'(nstart[0] - s0), 64'd4);
    check("post_rst_result", {32'd0, res0}, 64'd10);

    // Counter stuck busy: abort exactly 100 cycles after WAIT_BUSY entry.
    prep(0);
    hold[0] = 1'b1;
    s0 = nstart[0];
    v0 = nvalid[0];
    launch(0);
    k = 0;
    while (nstart[0] == s0 && k < 10) begin tick(); k++; end
    check("to_start_seen", 64'(nstart[0] - s0), 64'd1);
    k = 0;
    while (cyc < startcyc[0] + 100 && k < 200) begin tick(); k++; end
    check("to_not_yet", {63'd0, tout[0]}, 64'd0);
    check("to_busy_before", {63'd0, obusy[0]}, 64'd1);
    tick();
    check("to_flag", {63'd0, tout[0]}, 64'd1);
    check("to_busy_after", {63'd0, obusy[0]}, 64'd0);
    check("to_result_kept", {32'd0, res0}, 64'd10);
    check("to_no_valid", 64'(nvalid[0] - v0), 64'd0);
    repeat (5) tick();
    check("to_sticky", {63'd0, tout[0]}, 64'd1);

    // Retrigger while counter still busy from the aborted run.
    s0 = nstart[0];
    launch(0);
    check("rt_timeout_clr", {63'd0, tout[0]}, 64'd0);
    check("rt_busy", {63'd0, obusy[0]}, 64'd1);
    repeat (5) tick();
    check("rt_no_start", 64'(nstart[0] - s0), 64'd0);
    hold[0] = 1'b0;
    k = 0;
    while (nstart[0] == s0 && k < 20) begin tick(); k++; end
    hold[0] = 1'b1;
    check("rt_one_start", 64'(nstart[0] - s0), 64'd1);
    wait_idle(0, 200, "rt_abort_done");
    check("rt_single_start", 64'(nstart[0] - s0), 64'd1);
    check("rt_timeout_again", {63'd0, tout[0]}, 64'd1);
    hold[0] = 1'b0;
    repeat (10) tick();
    prep(0);

    // Unit 1 (2 samples): full-scale sum and min/max.
    prep(1);
    samp[1][0] = 32'hFFFF_FFFF; samp[1][1] = 32'hFFFF_FFFF;
    push_exp(1, 2, 32'hFFFF_FFFF);
    launch(1);
    wait_idle(1, 100, "u1_full_done");
    check("u1_full_result", {32'd0, res1}, 64'hFFFF_FFFF);
    prep(1);
    samp[1][0] = 32'd5; samp[1][1] = 32'd9;
    push_exp(1, 2, 32'd7);
    s0 = nstart[1];
    launch(1);
    wait_idle(1, 100, "u1_mm_done");
    check("u1_mm_starts", 64'(nstart[1] - s0), 64'd2);
    check("u1_mm_result", {32'd0, res1}, 64'd7);
`ifdef MEAS_CTRL_MINMAX_EN
    check("u1_min_hold", {32'd0, mn1}, 64'd5);
    check("u1_max_hold", {32'd0, mx1}, 64'd9);
`endif

    repeat (5) tick();
    check("sb_drained", 64'(rd), 64'(sb.size()));
    check("start_while_busy", 64'(viol), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_meas_ctrl

`default_nettype wire
